// File: rtl/core_sequencer_if.sv
// Shared memory bus between the sequencer (master) and the memory system (slave).
interface core_sequencer_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, execute, optional memory access, writeback.
// Drives one shared memory port and qualifies the external decoder's results.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic              clk,
    input  logic              reset_i,
    core_sequencer_if.master  mem,
    output logic [31:0]       instr_o,
    output logic              decode_en_o,
    input  logic [1:0]        next_pc_sel_i,
    input  logic [31:0]       addr_i,
    input  logic              d_we_i,
    input  logic              reg_in_en_i,
    output logic              reg_we_o,
    output logic [31:0]       mdr_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       instret_o,
    output logic              halt_o
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_HALT
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] instret_q, instret_d;

    logic        req, we, dec_en, rf_we;
    logic [31:0] addr;
    logic [6:0]  opcode;

    assign opcode = instr_q[6:0];

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        mdr_d     = mdr_q;
        instret_d = instret_q;
        req       = 1'b0;
        we        = 1'b0;
        addr      = '0;
        dec_en    = 1'b0;
        rf_we     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (pc_q[1:0] != 2'b00) begin
                    state_d = S_HALT;
                end else begin
                    req  = 1'b1;
                    addr = pc_q;
                    if (mem.mem_ack_i) begin
                        instr_d = mem.mem_rdata_i;
                        state_d = S_EXECUTE;
                    end
                end
            end
            S_EXECUTE: begin
                dec_en = 1'b1;
                if (instr_q[1:0] != 2'b11 || opcode == OP_SYSTEM) begin
                    state_d = S_HALT;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                dec_en = 1'b1;
                req    = 1'b1;
                addr   = addr_i;
                we     = d_we_i;
                if (mem.mem_ack_i) begin
                    if (opcode == OP_LOAD) begin
                        mdr_d = mem.mem_rdata_i;
                    end
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                dec_en    = 1'b1;
                rf_we     = reg_in_en_i;
                instret_d = instret_q + 32'd1;
                case (next_pc_sel_i)
                    2'b01:   pc_d = pc_q + addr_i;
                    2'b11:   pc_d = addr_i;
                    default: pc_d = pc_q + 32'd4;
                endcase
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // Strobes stay quiet for the whole reset cycle, whatever state is being overridden.
        if (reset_i) begin
            req    = 1'b0;
            we     = 1'b0;
            dec_en = 1'b0;
            rf_we  = 1'b0;
        end
    end

    assign mem.mem_req_o  = req;
    assign mem.mem_we_o   = we;
    assign mem.mem_addr_o = addr;
    assign decode_en_o    = dec_en;
    assign reg_we_o       = rf_we;
    assign instr_o        = instr_q;
    assign mdr_o          = mdr_q;
    assign pc_o           = pc_q;
    assign instret_o      = instret_q;
    assign halt_o         = (state_q == S_HALT);

endmodule

// File: tb/tb_core_sequencer.sv
// Directed and randomized checks of core_sequencer against an instruction-level model.
module tb_core_sequencer;
    localparam logic [31:0] RST_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] instr_o;
    logic        decode_en_o;
    logic [1:0]  next_pc_sel_i;
    logic [31:0] addr_i;
    logic        d_we_i;
    logic        reg_in_en_i;
    logic        reg_we_o;
    logic [31:0] mdr_o;
    logic [31:0] pc_o;
    logic [31:0] instret_o;
    logic        halt_o;

    core_sequencer_if mem_if ();

    core_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .mem           (mem_if.master),
        .instr_o       (instr_o),
        .decode_en_o   (decode_en_o),
        .next_pc_sel_i (next_pc_sel_i),
        .addr_i        (addr_i),
        .d_we_i        (d_we_i),
        .reg_in_en_i   (reg_in_en_i),
        .reg_we_o      (reg_we_o),
        .mdr_o         (mdr_o),
        .pc_o          (pc_o),
        .instret_o     (instret_o),
        .halt_o        (halt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Architectural model: program counter, retire count, load data register.
    logic [31:0] pc_m, instret_m, mdr_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_dec();
        next_pc_sel_i = 2'($urandom);
        addr_i        = $urandom;
        d_we_i        = 1'($urandom);
        reg_in_en_i   = 1'($urandom);
    endtask

    task automatic do_reset(input logic pending_ack);
        reset_i = 1'b1;
        rand_dec();
        mem_if.mem_ack_i   = pending_ack;
        mem_if.mem_rdata_i = $urandom;
        #1;
        chk("rst_req", {31'd0, mem_if.mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_if.mem_we_o}, 32'd0);
        chk("rst_dec", {31'd0, decode_en_o}, 32'd0);
        chk("rst_regwe", {31'd0, reg_we_o}, 32'd0);
        tick();
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_mdr", mdr_o, 32'd0);
        chk("rst_instret", instret_o, 32'd0);
        chk("rst_halt", {31'd0, halt_o}, 32'd0);
        chk("rst_req_hold", {31'd0, mem_if.mem_req_o}, 32'd0);
        reset_i   = 1'b0;
        mem_if.mem_ack_i = 1'b0;
        pc_m      = RST_PC;
        instret_m = '0;
        mdr_m     = '0;
        #1;
        chk("post_rst_req", {31'd0, mem_if.mem_req_o}, 32'd1);
        chk("post_rst_addr", mem_if.mem_addr_o, RST_PC);
    endtask

    // Runs one instruction cycle by cycle; abort_at>=0 stops inside the memory wait.
    task automatic exec_instr(input logic [31:0] instr, input logic [1:0] sel,
                              input logic [31:0] addr, input logic we, input logic rin,
                              input int fw, input int mw, input logic [31:0] rdata,
                              input int abort_at);
        logic [6:0] op;
        op = instr[6:0];
        for (int i = 0; i <= fw; i++) begin
            rand_dec();
            mem_if.mem_ack_i   = (i == fw);
            mem_if.mem_rdata_i = (i == fw) ? instr : $urandom;
            #1;
            chk("fetch_req", {31'd0, mem_if.mem_req_o}, 32'd1);
            chk("fetch_addr", mem_if.mem_addr_o, pc_m);
            chk("fetch_we", {31'd0, mem_if.mem_we_o}, 32'd0);
            chk("fetch_dec", {31'd0, decode_en_o}, 32'd0);
            chk("fetch_regwe", {31'd0, reg_we_o}, 32'd0);
            tick();
        end
        chk("instr", instr_o, instr);

        next_pc_sel_i = sel;
        addr_i        = addr;
        d_we_i        = we;
        reg_in_en_i   = rin;
        mem_if.mem_ack_i   = 1'($urandom);
        mem_if.mem_rdata_i = $urandom;
        #1;
        chk("exec_dec", {31'd0, decode_en_o}, 32'd1);
        chk("exec_req", {31'd0, mem_if.mem_req_o}, 32'd0);
        chk("exec_regwe", {31'd0, reg_we_o}, 32'd0);
        tick();

        if (instr[1:0] != 2'b11 || op == 7'b1110011) begin
            chk("halt_enter", {31'd0, halt_o}, 32'd1);
            chk("halt_pc", pc_o, pc_m);
            chk("halt_instret", instret_o, instret_m);
            return;
        end

        if (op == 7'b0000011 || op == 7'b0100011) begin
            for (int i = 0; i <= mw; i++) begin
                if (i == abort_at) return;
                mem_if.mem_ack_i   = (i == mw);
                mem_if.mem_rdata_i = (i == mw) ? rdata : $urandom;
                #1;
                chk("mem_req", {31'd0, mem_if.mem_req_o}, 32'd1);
                chk("mem_addr", mem_if.mem_addr_o, addr);
                chk("mem_we", {31'd0, mem_if.mem_we_o}, {31'd0, we});
                chk("mem_dec", {31'd0, decode_en_o}, 32'd1);
                chk("mem_regwe", {31'd0, reg_we_o}, 32'd0);
                tick();
            end
            if (op == 7'b0000011) mdr_m = rdata;
        end

        mem_if.mem_ack_i   = 1'($urandom);
        mem_if.mem_rdata_i = $urandom;
        #1;
        chk("wb_regwe", {31'd0, reg_we_o}, {31'd0, rin});
        chk("wb_dec", {31'd0, decode_en_o}, 32'd1);
        chk("wb_req", {31'd0, mem_if.mem_req_o}, 32'd0);
        tick();
        case (sel)
            2'b01:   pc_m = pc_m + addr;
            2'b11:   pc_m = addr;
            default: pc_m = pc_m + 32'd4;
        endcase
        instret_m = instret_m + 32'd1;
        chk("pc", pc_o, pc_m);
        chk("instret", instret_o, instret_m);
        chk("mdr", mdr_o, mdr_m);
        chk("regwe_after_wb", {31'd0, reg_we_o}, 32'd0);
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) begin
            rand_dec();
            mem_if.mem_ack_i   = 1'($urandom);
            mem_if.mem_rdata_i = $urandom;
            #1;
            chk("hold_halt", {31'd0, halt_o}, 32'd1);
            chk("hold_req", {31'd0, mem_if.mem_req_o}, 32'd0);
            chk("hold_dec", {31'd0, decode_en_o}, 32'd0);
            chk("hold_pc", pc_o, pc_m);
            chk("hold_instret", instret_o, instret_m);
            tick();
        end
    endtask

    initial begin
        logic [31:0] r, instr, addr, rdata;
        logic [1:0]  sel;
        int          cls;

        reset_i            = 1'b1;
        mem_if.mem_ack_i   = 1'b0;
        mem_if.mem_rdata_i = '0;
        rand_dec();
        tick();
        do_reset(1'b0);

        // ADDI, LW with five wait states, JAL back to 0, SW to 0x100
        exec_instr(32'h00500093, 2'b00, 32'h0, 1'b0, 1'b1, 0, 0, 32'h0, -1);
        exec_instr(32'h0000a103, 2'b00, 32'h00000200, 1'b0, 1'b1, 0, 5, 32'hDEADBEEF, -1);
        chk("lw_mdr", mdr_o, 32'hDEADBEEF);
        exec_instr(32'h0000006f, 2'b01, 32'hFFFFFFF8, 1'b0, 1'b1, 1, 0, 32'h0, -1);
        chk("jal_pc", pc_o, 32'h0);
        exec_instr(32'h00202023, 2'b00, 32'h00000100, 1'b1, 1'b0, 0, 2, 32'h12345678, -1);

        for (int n = 0; n < 40; n++) begin
            r     = $urandom;
            cls   = int'($urandom_range(0, 4));
            rdata = $urandom;
            addr  = $urandom;
            sel   = 2'b00;
            case (cls)
                0: instr = {r[31:7], 7'b0010011};
                1: instr = {r[31:7], 7'b0000011};
                2: instr = {r[31:7], 7'b0100011};
                3: begin
                    instr = {r[31:7], 7'b1100011};
                    sel   = r[8] ? 2'b01 : 2'b10;
                    addr  = {addr[31:2], 2'b00};
                end
                default: begin
                    instr = {r[31:7], 7'b1101111};
                    sel   = r[9] ? 2'b11 : 2'b01;
                    addr  = {addr[31:2], 2'b00};
                end
            endcase
            exec_instr(instr, sel, addr, (cls == 2), 1'($urandom), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), rdata, -1);
        end

        // retire counter wraps from all ones to zero
        do_reset(1'b0);
        force dut.instret_q = 32'hFFFFFFFF;
        #1;
        release dut.instret_q;
        #1;
        instret_m = 32'hFFFFFFFF;
        chk("forced_instret", instret_o, 32'hFFFFFFFF);
        exec_instr(32'h00100013, 2'b00, 32'h0, 1'b0, 1'b0, 0, 0, 32'h0, -1);
        chk("instret_wrap", instret_o, 32'h0);

        // JALR to a misaligned target halts at the next fetch without a request
        exec_instr(32'h00008067, 2'b11, 32'h00000006, 1'b0, 1'b1, 0, 0, 32'h0, -1);
        #1;
        chk("misalign_req", {31'd0, mem_if.mem_req_o}, 32'd0);
        tick();
        chk("misalign_halt", {31'd0, halt_o}, 32'd1);
        halt_hold(4);

        do_reset(1'b0);
        exec_instr(32'h00000073, 2'b00, 32'h0, 1'b0, 1'b1, 2, 0, 32'h0, -1);
        halt_hold(4);

        do_reset(1'b0);
        exec_instr(32'h00000013, 2'b00, 32'h0, 1'b0, 1'b1, 0, 0, 32'h0, -1);
        exec_instr(32'h00000000, 2'b00, 32'h0, 1'b0, 1'b1, 0, 0, 32'h0, -1);
        halt_hold(4);

        // reset lands while a load is still waiting for its ack
        do_reset(1'b0);
        exec_instr(32'h00000013, 2'b00, 32'h0, 1'b0, 1'b1, 0, 0, 32'h0, -1);
        exec_instr(32'h0040a183, 2'b00, 32'h00000300, 1'b0, 1'b1, 0, 10, 32'hCAFEF00D, 3);
        do_reset(1'b1);
        exec_instr(32'h00500093, 2'b00, 32'h0, 1'b0, 1'b1, 0, 0, 32'h0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
